// File: rtl/ifft64_out_reorder.sv
// Converts the bit-reversed 2-lane IFFT output stream into natural order.
// Ping-pong banks; define IFFT_REORDER_IDX_EN to add the out_idx port.
module ifft64_out_reorder #(
  parameter int DW    = 16,
  parameter int LOG2N = 6
) (
  input  logic             clk,
  input  logic             arstn,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [DW-1:0]    in0_re,
  input  logic [DW-1:0]    in0_im,
  input  logic [DW-1:0]    in1_re,
  input  logic [DW-1:0]    in1_im,
  output logic             out_valid,
  output logic [DW-1:0]    out0_re,
  output logic [DW-1:0]    out0_im,
  output logic [DW-1:0]    out1_re,
  output logic [DW-1:0]    out1_im,
`ifdef IFFT_REORDER_IDX_EN
  output logic [LOG2N-1:0] out_idx,
`endif
  output logic             out_last
);

  localparam int N  = 2**LOG2N;
  localparam int BW = LOG2N-1;

  typedef enum logic {IDLE, READ} state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   wc_q, wc_d;
  logic [BW-1:0]   rc_q, rc_d;
  logic            wbank_q, wbank_d;
  logic            rbank_q, rbank_d;
  logic            ov_q, ov_d;
  logic            ol_q, ol_d;
  logic [DW-1:0]   o0r_q, o0r_d;
  logic [DW-1:0]   o0i_q, o0i_d;
  logic [DW-1:0]   o1r_q, o1r_d;
  logic [DW-1:0]   o1i_q, o1i_d;
  logic [LOG2N-1:0] idx_q, idx_d;

  logic [2*DW-1:0] mem_q [2*N];

  logic            beat;
  logic            frame_done;
  logic [BW-1:0]   wc_rev;
  logic [LOG2N:0]  waddr0, waddr1;
  logic [LOG2N:0]  raddr0, raddr1;
  logic [2*DW-1:0] rd0, rd1;

  always_comb begin
    wc_rev = '0;
    for (int i = 0; i < BW; i++) begin
      wc_rev[BW-1-i] = wc_q[i];
    end
  end

  assign beat       = in_valid && !clr;
  assign frame_done = beat && (wc_q == {BW{1'b1}});
  assign waddr0     = {wbank_q, 1'b0, wc_rev};
  assign waddr1     = {wbank_q, 1'b1, wc_rev};
  assign raddr0     = {rbank_q, rc_q, 1'b0};
  assign raddr1     = {rbank_q, rc_q, 1'b1};
  assign rd0        = mem_q[raddr0];
  assign rd1        = mem_q[raddr1];

  // Sample storage carries no reset; stale data is never read back.
  always_ff @(posedge clk) begin
    if (beat) begin
      mem_q[waddr0] <= {in0_re, in0_im};
      mem_q[waddr1] <= {in1_re, in1_im};
    end
  end

  always_comb begin
    wc_d    = wc_q;
    wbank_d = wbank_q;
    state_d = state_q;
    rc_d    = rc_q;
    rbank_d = rbank_q;
    ov_d    = 1'b0;
    ol_d    = 1'b0;
    o0r_d   = o0r_q;
    o0i_d   = o0i_q;
    o1r_d   = o1r_q;
    o1i_d   = o1i_q;
    idx_d   = idx_q;

    if (beat) begin
      wc_d = wc_q + 1'b1;
    end
    if (frame_done) begin
      wbank_d = ~wbank_q;
    end

    unique case (state_q)
      IDLE: begin
      end
      READ: begin
        ov_d  = 1'b1;
        ol_d  = (rc_q == {BW{1'b1}});
        o0r_d = rd0[2*DW-1:DW];
        o0i_d = rd0[DW-1:0];
        o1r_d = rd1[2*DW-1:DW];
        o1i_d = rd1[DW-1:0];
        idx_d = {rc_q, 1'b0};
        rc_d  = rc_q + 1'b1;
        if (rc_q == {BW{1'b1}}) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A completing frame hands its bank to the reader on the same edge.
    if (frame_done) begin
      state_d = READ;
      rc_d    = '0;
      rbank_d = wbank_q;
    end

    if (clr) begin
      wc_d    = '0;
      state_d = IDLE;
      rc_d    = '0;
      ov_d    = 1'b0;
      ol_d    = 1'b0;
      idx_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q <= IDLE;
      wc_q    <= '0;
      rc_q    <= '0;
      wbank_q <= 1'b0;
      rbank_q <= 1'b0;
      ov_q    <= 1'b0;
      ol_q    <= 1'b0;
      o0r_q   <= '0;
      o0i_q   <= '0;
      o1r_q   <= '0;
      o1i_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      wc_q    <= wc_d;
      rc_q    <= rc_d;
      wbank_q <= wbank_d;
      rbank_q <= rbank_d;
      ov_q    <= ov_d;
      ol_q    <= ol_d;
      o0r_q   <= o0r_d;
      o0i_q   <= o0i_d;
      o1r_q   <= o1r_d;
      o1i_q   <= o1i_d;
      idx_q   <= idx_d;
    end
  end

  assign out_valid = ov_q;
  assign out_last  = ol_q;
  assign out0_re   = o0r_q;
  assign out0_im   = o0i_q;
  assign out1_re   = o1r_q;
  assign out1_im   = o1i_q;
`ifdef IFFT_REORDER_IDX_EN
  assign out_idx   = idx_q;
`else
  logic unused_idx;
  assign unused_idx = ^idx_q;
`endif

endmodule

// File: tb/tb_ifft64_out_reorder.sv
// Scoreboard bench for ifft64_out_reorder: natural-order frames,
// gaps, flush, mid-read reset, optional index output.
module tb_ifft64_out_reorder;

  logic        clk = 1'b0;
  logic        arstn;
  logic        clr;
  logic        in_valid;
  logic [15:0] in0_re, in0_im, in1_re, in1_im;
  logic        out_valid, out_last;
  logic [15:0] out0_re, out0_im, out1_re, out1_im;
`ifdef IFFT_REORDER_IDX_EN
  logic [5:0]  out_idx;
`endif

  always #5 clk = ~clk;

  ifft64_out_reorder dut (
    .clk(clk), .arstn(arstn), .clr(clr), .in_valid(in_valid),
    .in0_re(in0_re), .in0_im(in0_im),
    .in1_re(in1_re), .in1_im(in1_im),
    .out_valid(out_valid),
    .out0_re(out0_re), .out0_im(out0_im),
    .out1_re(out1_re), .out1_im(out1_im),
`ifdef IFFT_REORDER_IDX_EN
    .out_idx(out_idx),
`endif
    .out_last(out_last)
  );

  typedef struct packed {
    logic [15:0] r0, i0, r1, i1;
    logic        last;
    logic [5:0]  idx;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   run = 0;
  int   last_run = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] bitrev6(input logic [5:0] x);
    logic [5:0] r;
    for (int i = 0; i < 6; i++) r[5-i] = x[i];
    return r;
  endfunction

  function automatic logic [15:0] val(input int f, input int n,
                                      input bit c);
    int v;
    v = n + 64 * f;
    return c ? 16'h1234 : v[15:0];
  endfunction

  task automatic push_frame(input int f, input bit c);
    exp_t e;
    for (int k = 0; k < 32; k++) begin
      e.r0   = val(f, 2*k, c);
      e.i0   = ~e.r0;
      e.r1   = val(f, 2*k+1, c);
      e.i1   = ~e.r1;
      e.last = (k == 31);
      e.idx  = 6'(2*k);
      sb.push_back(e);
    end
  endtask

  task automatic drive_beats(input int f, input int nb, input bit gaps,
                             input bit c);
    logic [4:0] w;
    logic [5:0] n0, n1;
    for (int b = 0; b < nb; b++) begin
      if (gaps && b > 0) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      w  = b[4:0];
      n0 = bitrev6({w, 1'b0});
      n1 = bitrev6({w, 1'b1});
      in_valid = 1'b1;
      in0_re = val(f, int'(n0), c);
      in0_im = ~in0_re;
      in1_re = val(f, int'(n1), c);
      in1_im = ~in1_re;
    end
  endtask

  task automatic drive_frame(input int f, input bit gaps, input bit c);
    push_frame(f, c);
    drive_beats(f, 32, gaps, c);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && sb.size() > 0; i++) @(posedge clk);
    chk("drain", 32'(sb.size()), 32'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_last"}, 32'(out_last), 32'd0);
    chk({tag, "_o0re"}, 32'(out0_re), 32'd0);
    chk({tag, "_o0im"}, 32'(out0_im), 32'd0);
    chk({tag, "_o1re"}, 32'(out1_re), 32'd0);
    chk({tag, "_o1im"}, 32'(out1_im), 32'd0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!arstn) begin
      run = 0;
    end else if (out_valid) begin
      run++;
      if (sb.size() == 0) begin
        chk("unexpected_beat", 32'(out_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("o0re", 32'(out0_re), 32'(e.r0));
        chk("o0im", 32'(out0_im), 32'(e.i0));
        chk("o1re", 32'(out1_re), 32'(e.r1));
        chk("o1im", 32'(out1_im), 32'(e.i1));
        chk("last", 32'(out_last), 32'(e.last));
`ifdef IFFT_REORDER_IDX_EN
        chk("idx", 32'(out_idx), 32'(e.idx));
`endif
      end
    end else begin
      chk("last_idle", 32'(out_last), 32'd0);
      if (run > 0) last_run = run;
      run = 0;
    end
  end

  initial begin
    arstn = 1'b0; clr = 1'b0; in_valid = 1'b0;
    in0_re = '0; in0_im = '0; in1_re = '0; in1_im = '0;
    #1;
    chk_zero("rst");
    repeat (3) @(posedge clk);
    #1;
    arstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("post_rst");

    // single frame, latency
    drive_frame(0, 1'b0, 1'b0);
    idle();
    chk("lat_pre", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk("lat_beat0", 32'(out_valid), 32'd1);
    chk("lat_beat0_re", 32'(out0_re), 32'd0);
    drain();

    // three back-to-back frames
    drive_frame(1, 1'b0, 1'b0);
    drive_frame(2, 1'b0, 1'b0);
    drive_frame(3, 1'b0, 1'b0);
    idle();
    drain();
    chk("run96", 32'(last_run), 32'd96);

    // gapped input
    drive_frame(0, 1'b1, 1'b0);
    idle();
    chk("gap_lat_pre", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk("gap_lat_beat0", 32'(out_valid), 32'd1);
    drain();

    // flush after partial frame
    drive_beats(7, 10, 1'b0, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    drive_frame(0, 1'b0, 1'b1);
    idle();
    drain();

    // reset during output beat 15
    drive_frame(4, 1'b0, 1'b0);
    idle();
    repeat (16) @(posedge clk);
    #1;
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    arstn = 1'b0;
    sb.delete();
    #1;
    chk_zero("mid_rst");
    repeat (3) @(posedge clk);
    #1;
    chk_zero("mid_rst_hold");
    arstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("mid_rst_rel");
    drive_frame(5, 1'b0, 1'b0);
    idle();
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
